phyretrain_ctrl_gen2: RTL

PHYRETRAIN_CTRL_GEN2 -- requirements
Module: phyretrain_ctrl_gen2

---
 rtl/ltsm_pkg.sv | 37 +++
 rtl/ltsm_timeout_cnt.sv | 59 +++++
 rtl/phyretrain_ctrl_gen2.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ltsm_pkg.sv
// Shared LTSM definitions: sideband message codes, retrain codes, FSM states.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package ltsm_pkg;

  // Sideband message codes; zero-extended to the message width at use sites.
  typedef enum logic [1:0] {
    MSG_NONE       = 2'd0,
    MSG_START_REQ  = 2'd1,
    MSG_START_RESP = 2'd2
  } sb_msg_e;

  // Retrain codes; a larger value is the more conservative action.
  typedef enum logic [1:0] {
    RT_NONE      = 2'd0,
    RT_TXSELFCAL = 2'd1,
    RT_REPAIR    = 2'd2,
    RT_SPEEDIDLE = 2'd3
  } retrain_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_REQ,
    ST_HANDSHAKE,
    ST_DONE,
    ST_TIMEOUT
  } ltsm_state_e;

  // Both sides must agree on one code, so take the larger one. A partner
  // that reported nothing (0) defers to the local request.
  function automatic logic [1:0] resolve_code(input logic [1:0] local_code,
                                              input logic [1:0] partner_code);
    if (partner_code == 2'd0) return local_code;
    return (partner_code > local_code) ? partner_code : local_code;
  endfunction

endpackage

// File: rtl/ltsm_timeout_cnt.sv
// Handshake timeout counter with retry tally for the retrain controller.
// Latency: o_expired is combinational on the last count; state updates next edge.
// Backpressure: none; counts whenever i_cnt_en is high, i_clr wins over counting.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_clr              zero counter and retry tally
//   i_cnt_en           advance the counter this cycle
//   i_retry_inc        record one retransmission
//   o_expired          counter is at its last value while enabled (wraps next edge)
//   o_retry_avail      fewer than MAX_RETRY retransmissions used so far
module ltsm_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_RETRY      = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_cnt_en,
  input  logic i_retry_inc,
  output logic o_expired,
  output logic o_retry_avail
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;

  assign o_expired     = i_cnt_en && (cnt_q == CNT_LAST);
  assign o_retry_avail = (retry_q < RETRY_MAX);

  always_comb begin
    cnt_d   = cnt_q;
    retry_d = retry_q;
    if (i_clr) begin
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      if (i_cnt_en) cnt_d = o_expired ? '0 : cnt_q + 1'b1;
      // Saturate so the tally can never wrap back into "retries available".
      if (i_retry_inc && o_retry_avail) retry_d = retry_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

endmodule

// File: rtl/phyretrain_ctrl_gen2.sv
// PHYRETRAIN handshake controller: exchanges START_REQ/START_RESP with the link partner and resolves the retrain code.
// Latency: sideband sends appear one cycle after the non-busy cycle that decides them; DONE one cycle after both resp flags set.
// Backpressure: i_SB_Busy stalls every send; a pending RESP is served before a pending REQ retry.
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_phyretrain_en                   enable; dropping it aborts back to IDLE
//   i_enter_from_active_or_mbtrain    0 = entered from ACTIVE, 1 = from MBTRAIN.LINKSPEED
//   i_linkspeed_lanes_status          local retrain request code
//   i_decoded_SB_msg, i_rx_msg_valid  received sideband message and its strobe
//   i_rx_msg_info                     partner retrain code in [1:0]
//   i_SB_Busy                         sideband transmitter busy
//   i_clear_resolved_state            zero o_resolved_state
//   o_encoded_SB_msg, o_tx_msg_valid, o_tx_msg_info   one-cycle send
//   o_PHYRETRAIN_end, o_timeout       terminal status, held until disabled
//   o_resolved_state                  agreed retrain code
module phyretrain_ctrl_gen2
  import ltsm_pkg::*;
#(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_RETRY      = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_phyretrain_en,
  input  logic                    i_enter_from_active_or_mbtrain,
  input  logic [1:0]              i_linkspeed_lanes_status,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
  input  logic                    i_rx_msg_valid,
  input  logic [2:0]              i_rx_msg_info,
  input  logic                    i_SB_Busy,
  input  logic                    i_clear_resolved_state,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg,
  output logic                    o_tx_msg_valid,
  output logic [2:0]              o_tx_msg_info,
  output logic                    o_PHYRETRAIN_end,
  output logic [1:0]              o_resolved_state,
  output logic                    o_timeout
);

  localparam logic [SB_MSG_WIDTH-1:0] MSG_REQ_W  = SB_MSG_WIDTH'(MSG_START_REQ);
  localparam logic [SB_MSG_WIDTH-1:0] MSG_RESP_W = SB_MSG_WIDTH'(MSG_START_RESP);

  ltsm_state_e state_q, state_d;
  logic [1:0] local_code_q, local_code_d;
  logic [1:0] partner_code_q, partner_code_d;
  logic [1:0] resolved_q, resolved_d;
  logic       req_rcvd_q, req_rcvd_d;
  logic       resp_rcvd_q, resp_rcvd_d;
  logic       resp_sent_q, resp_sent_d;
  logic       req_pend_q, req_pend_d;
  logic       tx_vld_q, tx_vld_d;
  logic [SB_MSG_WIDTH-1:0] tx_msg_q, tx_msg_d;
  logic [2:0] tx_info_q, tx_info_d;

  logic       rx_req, rx_resp, rx_accept;
  logic       req_due;
  logic [1:0] resolved_code;
  logic       cnt_clr, cnt_en, retry_inc, expired, retry_avail;
  logic       rx_info_unused;

  assign rx_info_unused = i_rx_msg_info[2];

  assign rx_req  = i_rx_msg_valid && (i_decoded_SB_msg == MSG_REQ_W);
  assign rx_resp = i_rx_msg_valid && (i_decoded_SB_msg == MSG_RESP_W);
  // Accept partner messages from IDLE too, so a partner that starts first is not lost.
  assign rx_accept = i_phyretrain_en &&
                     (state_q inside {ST_IDLE, ST_SEND_REQ, ST_HANDSHAKE});
  assign resolved_code = resolve_code(local_code_q, partner_code_q);

  // Counter only runs inside HANDSHAKE; leaving it (or disabling) wipes count and retries.
  assign cnt_clr = (state_q != ST_HANDSHAKE) || !i_phyretrain_en;

  ltsm_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MAX_RETRY      (MAX_RETRY)
  ) u_timeout_cnt (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_clr         (cnt_clr),
    .i_cnt_en      (cnt_en),
    .i_retry_inc   (retry_inc),
    .o_expired     (expired),
    .o_retry_avail (retry_avail)
  );

  always_comb begin
    state_d        = state_q;
    local_code_d   = local_code_q;
    partner_code_d = partner_code_q;
    req_rcvd_d     = req_rcvd_q;
    resp_rcvd_d    = resp_rcvd_q;
    resp_sent_d    = resp_sent_q;
    req_pend_d     = req_pend_q;
    resolved_d     = resolved_q;
    tx_vld_d       = 1'b0;
    tx_msg_d       = '0;
    tx_info_d      = '0;
    cnt_en         = 1'b0;
    retry_inc      = 1'b0;
    req_due        = 1'b0;

    if (i_clear_resolved_state) resolved_d = '0;

    if (rx_accept && rx_req) begin
      req_rcvd_d     = 1'b1;
      partner_code_d = i_rx_msg_info[1:0];
    end
    if (rx_accept && rx_resp) resp_rcvd_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (i_phyretrain_en) begin
          state_d      = ST_SEND_REQ;
          local_code_d = i_enter_from_active_or_mbtrain ? RT_SPEEDIDLE : i_linkspeed_lanes_status;
        end
      end
      ST_SEND_REQ: begin
        if (!i_phyretrain_en) begin
          state_d = ST_IDLE;
        end else if (!i_SB_Busy) begin
          tx_vld_d  = 1'b1;
          tx_msg_d  = MSG_REQ_W;
          tx_info_d = {1'b0, local_code_q};
          state_d   = ST_HANDSHAKE;
        end
      end
      ST_HANDSHAKE: begin
        if (!i_phyretrain_en) begin
          state_d = ST_IDLE;
        end else if (resp_rcvd_q && resp_sent_q) begin
          state_d    = ST_DONE;
          resolved_d = resolved_code;   // load beats a same-cycle clear
        end else begin
          cnt_en  = !resp_rcvd_q;
          req_due = req_pend_q;
          if (expired && !retry_avail) begin
            state_d = ST_TIMEOUT;
          end else begin
            if (expired) begin
              retry_inc = 1'b1;
              req_due   = 1'b1;
            end
            // RESP has priority: the partner is already waiting on it.
            if (!i_SB_Busy && req_rcvd_q && !resp_sent_q) begin
              tx_vld_d    = 1'b1;
              tx_msg_d    = MSG_RESP_W;
              tx_info_d   = {1'b0, resolved_code};
              resp_sent_d = 1'b1;
            end else if (!i_SB_Busy && req_due) begin
              tx_vld_d  = 1'b1;
              tx_msg_d  = MSG_REQ_W;
              tx_info_d = {1'b0, local_code_q};
              req_due   = 1'b0;
            end
            req_pend_d = req_due;
          end
        end
      end
      ST_DONE, ST_TIMEOUT: begin
        if (!i_phyretrain_en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Disable aborts the exchange; nothing from this attempt may leak into the next.
    if (!i_phyretrain_en) begin
      req_rcvd_d     = 1'b0;
      resp_rcvd_d    = 1'b0;
      resp_sent_d    = 1'b0;
      req_pend_d     = 1'b0;
      partner_code_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= ST_IDLE;
      local_code_q   <= '0;
      partner_code_q <= '0;
      resolved_q     <= '0;
      req_rcvd_q     <= 1'b0;
      resp_rcvd_q    <= 1'b0;
      resp_sent_q    <= 1'b0;
      req_pend_q     <= 1'b0;
      tx_vld_q       <= 1'b0;
      tx_msg_q       <= '0;
      tx_info_q      <= '0;
    end else begin
      state_q        <= state_d;
      local_code_q   <= local_code_d;
      partner_code_q <= partner_code_d;
      resolved_q     <= resolved_d;
      req_rcvd_q     <= req_rcvd_d;
      resp_rcvd_q    <= resp_rcvd_d;
      resp_sent_q    <= resp_sent_d;
      req_pend_q     <= req_pend_d;
      tx_vld_q       <= tx_vld_d;
      tx_msg_q       <= tx_msg_d;
      tx_info_q      <= tx_info_d;
    end
  end

  assign o_encoded_SB_msg = tx_msg_q;
  assign o_tx_msg_valid   = tx_vld_q;
  assign o_tx_msg_info    = tx_info_q;
  assign o_resolved_state = resolved_q;
  assign o_PHYRETRAIN_end = (state_q == ST_DONE);
  assign o_timeout        = (state_q == ST_TIMEOUT);

endmodule
